// File: rtl/core_seq_if.sv
// -----------------------------------------------------------------------------
// core_seq_if
// Instruction-fetch and data-memory handshake bundle for the core_seq
// sequencer.
//   master : sequencer side (drives requests, receives acks/data)
//   slave  : memory side    (drives acks/data, receives requests)
// Signals:
//   i_req   fetch request          i_ack  fetch complete, i_rdata valid
//   i_rdata fetched instruction    i_c    fetched word is an expanded RVC
//   d_req   data access request    d_we   1 = store, 0 = load
//   d_ack   data access complete
// -----------------------------------------------------------------------------
interface core_seq_if;
  logic        i_req;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_c;
  logic        d_req;
  logic        d_we;
  logic        d_ack;

  modport master (
    output i_req, d_req, d_we,
    input  i_ack, i_rdata, i_c, d_ack
  );

  modport slave (
    input  i_req, d_req, d_we,
    output i_ack, i_rdata, i_c, d_ack
  );
endinterface

// File: rtl/core_seq.sv
// -----------------------------------------------------------------------------
// core_seq
// Multi-cycle RV32I sequencer. Steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM | WB) -> FETCH, runs the fetch and data
// handshakes, and drives the PC unit, ALU and writeback controls from the
// latched instruction. Illegal instructions, ECALL/EBREAK and bus timeouts
// park the sequencer in a sticky TRAP state until rst.
//
// Parameters:
//   BUS_TIMEOUT : cycles without ack before a bus-timeout trap (0 disables)
// Optional feature macro:
//   RVC_ENABLE_EN : honour i_c (compressed fetch) for legality and PC+2
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus (master)        fetch/data handshake bundle
//   ir                  latched instruction
//   pc_load, pc_sel     PC unit strobe and select (00 +4, 10 +2, 01 TA, 11 +Imm)
//   alufn               ALU function code
//   zf, cf, vf, sf      ALU flags
//   alu_src_a/b         operand muxes (a: 0 rs1 / 1 PC, b: 0 rs2 / 1 Imm)
//   rf_we, wb_sel       register write enable, source (00 ALU, 01 load, 10 ftPC)
//   trap, trap_cause    sticky trap (01 illegal, 10 bus timeout, 11 ECALL/EBREAK)
//   state               debug view of the sequencer state
// -----------------------------------------------------------------------------
module core_seq #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  core_seq_if.master  bus,
  output logic [31:0] ir,
  output logic        pc_load,
  output logic [1:0]  pc_sel,
  output logic [3:0]  alufn,
  input  logic        zf,
  input  logic        cf,
  input  logic        vf,
  input  logic        sf,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  // Opcode classes, ir[6:2] (ir[1:0] is checked separately for RVC support)
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_ARI    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ARR    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // ALU function codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_PASS = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_ECALL   = 2'b11;

  localparam int            CW      = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);
  localparam bit            TO_EN   = (BUS_TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(BUS_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_ir;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cause;
  logic [1:0]    w_cause_nxt;

  logic          w_c_flag;
  logic          w_len_ok;
  logic [4:0]    w_opc;
  logic [2:0]    w_f3;
  logic          w_op_known;
  logic          w_illegal;
  logic          w_ecall;
  logic          w_timeout;
  logic          w_taken;
  logic [1:0]    w_ft_sel;

  assign w_opc = r_ir[6:2];
  assign w_f3  = r_ir[14:12];

  // ---------------------------------------------------------------------------
  // Compressed-instruction support
  // ---------------------------------------------------------------------------
`ifdef RVC_ENABLE_EN
  logic r_c_flag;

  always_ff @(posedge clk) begin
    if (rst)
      r_c_flag <= 1'b0;
    else if (r_state == S_FETCH && bus.i_ack)
      r_c_flag <= bus.i_c;
  end

  assign w_c_flag = r_c_flag;
  // An expanded compressed word carries no meaningful ir[1:0]
  assign w_len_ok = r_c_flag || (r_ir[1:0] == 2'b11);
`else
  logic w_unused_ic;
  assign w_unused_ic = bus.i_c;
  assign w_c_flag    = 1'b0;
  assign w_len_ok    = (r_ir[1:0] == 2'b11);
`endif

  assign w_ft_sel = w_c_flag ? 2'b10 : 2'b00;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case (w_opc)
      OP_LOAD, OP_ARI, OP_AUIPC, OP_STORE, OP_ARR,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: w_op_known = 1'b1;
      default:                                       w_op_known = 1'b0;
    endcase
  end

  assign w_illegal = !w_op_known || !w_len_ok
                  || (w_opc == OP_BRANCH && w_f3[2:1] == 2'b01)
                  || (w_opc == OP_SYSTEM && w_f3 != 3'b000);
  assign w_ecall   = (w_opc == OP_SYSTEM) && (w_f3 == 3'b000);

  // Counter holds the number of ack-less cycles already spent in this phase,
  // so the trap fires on the BUS_TIMEOUT-th such cycle.
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);

  always_comb begin
    unique case (w_f3)
      3'b000:  w_taken = zf;
      3'b001:  w_taken = !zf;
      3'b100:  w_taken = sf ^ vf;
      3'b101:  w_taken = !(sf ^ vf);
      3'b110:  w_taken = !cf;
      3'b111:  w_taken = cf;
      default: w_taken = 1'b0;
    endcase
  end

  function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
    unique case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State register and the other registered context
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= 32'h0000_0013;
      r_cnt   <= '0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      if (r_state == S_FETCH && bus.i_ack)
        r_ir <= bus.i_rdata;
      // Any state change clears the counter, so it starts at 0 on entry to
      // FETCH or MEM; staying in either of those means no ack arrived.
      if (w_state_nxt != r_state)
        r_cnt <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    unique case (r_state)
      S_FETCH: begin
        // An ack in the timeout cycle wins
        if (bus.i_ack) begin
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (w_illegal) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end else if (w_ecall) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_ECALL;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (w_opc)
          OP_ARR, OP_ARI, OP_LUI, OP_AUIPC: w_state_nxt = S_WB;
          OP_LOAD, OP_STORE:                w_state_nxt = S_MEM;
          default:                          w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (bus.d_ack) begin
          w_state_nxt = S_FETCH;
        end else if (w_timeout) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_TIMEOUT;
        end
      end
      S_WB:    w_state_nxt = S_FETCH;
      S_TRAP:  w_state_nxt = S_TRAP;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
    pc_load   = 1'b0;
    pc_sel    = w_ft_sel;
    alufn     = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'b00;

    // ALU controls stay valid through MEM/WB so the address/result is stable
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      unique case (w_opc)
        OP_ARR:   alufn = alu_map(w_f3, r_ir[30]);
        OP_ARI: begin
          // ir[30] is part of the immediate except for SRAI
          alufn     = alu_map(w_f3, (w_f3 == 3'b101) && r_ir[30]);
          alu_src_b = 1'b1;
        end
        OP_LUI: begin
          alufn     = ALU_PASS;
          alu_src_b = 1'b1;
        end
        OP_AUIPC: begin
          alu_src_a = 1'b1;
          alu_src_b = 1'b1;
        end
        OP_LOAD, OP_STORE, OP_JALR: alu_src_b = 1'b1;
        OP_BRANCH: alufn = ALU_SUB;
        default: ;
      endcase
    end

    unique case (r_state)
      S_FETCH: bus.i_req = 1'b1;
      S_EXEC: begin
        unique case (w_opc)
          OP_BRANCH: begin
            pc_load = 1'b1;
            pc_sel  = w_taken ? 2'b11 : w_ft_sel;
          end
          OP_JAL: begin
            rf_we   = 1'b1;
            wb_sel  = 2'b10;
            pc_load = 1'b1;
            pc_sel  = 2'b11;
          end
          OP_JALR: begin
            rf_we   = 1'b1;
            wb_sel  = 2'b10;
            pc_load = 1'b1;
            pc_sel  = 2'b01;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.d_req = 1'b1;
        bus.d_we  = (w_opc == OP_STORE);
        if (bus.d_ack) begin
          pc_load = 1'b1;
          if (w_opc == OP_LOAD) begin
            rf_we  = 1'b1;
            wb_sel = 2'b01;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_load = 1'b1;
      end
      default: ;
    endcase

    // Reset cycle: no request or state-changing strobe may leave the block
    if (rst) begin
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      pc_load   = 1'b0;
      rf_we     = 1'b0;
    end
  end

  assign ir         = r_ir;
  assign trap       = (r_state == S_TRAP);
  assign trap_cause = r_cause;
  assign state      = r_state;

endmodule

// File: tb/tb_core_seq.sv
// -----------------------------------------------------------------------------
// tb_core_seq
// Self-checking bench for core_seq. Each instruction is run through the DUT
// with chosen fetch/data wait states and ALU flags; a reference model derives
// the expected trap/path/controls from the instruction fields, and every
// cycle of the instruction is compared against it. Directed cases first,
// then randomized instructions. Honours RVC_ENABLE_EN when defined.
// -----------------------------------------------------------------------------
module tb_core_seq;

  localparam int TO = 4;

`ifdef RVC_ENABLE_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif

  // ALU codes: base operation per funct3, plus the SUB/SRA/PASS variants
  localparam logic [3:0] ALU_TAB [8] = '{4'b0000, 4'b1001, 4'b1101, 4'b1111,
                                         4'b0111, 4'b1000, 4'b0100, 4'b0101};
  localparam logic [3:0] A_ADD  = 4'b0000;
  localparam logic [3:0] A_SUB  = 4'b0001;
  localparam logic [3:0] A_PASS = 4'b0011;
  localparam logic [3:0] A_SRA  = 4'b1010;

  localparam int K_TRAP = 0;  // traps in DECODE
  localparam int K_WB   = 1;  // FETCH DECODE EXEC WB
  localparam int K_MEM  = 2;  // FETCH DECODE EXEC MEM
  localparam int K_CTRL = 3;  // FETCH DECODE EXEC (pc_load in EXEC)

  typedef struct {
    int         kind;
    logic [1:0] cause;
    logic       chk_alu;
    logic [3:0] alufn;
    logic       sa;
    logic       sb;
    logic       st;
    logic       ld;
    logic [1:0] sel;
    logic       rfwe;
    logic [1:0] ft;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        pc_load;
  logic [1:0]  pc_sel;
  logic [3:0]  alufn;
  logic        zf, cf, vf, sf;
  logic        alu_src_a, alu_src_b;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  core_seq_if bus ();

  core_seq #(.BUS_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .ir         (ir),
    .pc_load    (pc_load),
    .pc_sel     (pc_sel),
    .alufn      (alufn),
    .zf         (zf),
    .cf         (cf),
    .vf         (vf),
    .sf         (sf),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .rf_we      (rf_we),
    .wb_sel     (wb_sel),
    .trap       (trap),
    .trap_cause (trap_cause),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: outcome of one instruction from its fields and flags
  function automatic exp_t model(input logic [31:0] x, input logic c, input logic [3:0] fl);
    exp_t       e;
    logic [2:0] f3;
    logic       rvc, z, cy, v, s, tk;
    f3 = x[14:12];
    {z, cy, v, s} = fl;
    rvc = RVC && c;
    e.kind = K_TRAP; e.cause = 2'b01; e.chk_alu = 1'b1; e.alufn = A_ADD;
    e.sa = 1'b0; e.sb = 1'b0; e.st = 1'b0; e.ld = 1'b0;
    e.rfwe = 1'b0; e.ft = rvc ? 2'b10 : 2'b00; e.sel = e.ft;
    if (!rvc && x[1:0] != 2'b11) return e;
    case (x[6:2])
      5'b01100: begin  // OP (register)
        e.kind  = K_WB;
        e.alufn = (f3 == 3'd0 && x[30]) ? A_SUB :
                  (f3 == 3'd5 && x[30]) ? A_SRA : ALU_TAB[f3];
      end
      5'b00100: begin  // OP-IMM
        e.kind  = K_WB; e.sb = 1'b1;
        e.alufn = (f3 == 3'd5 && x[30]) ? A_SRA : ALU_TAB[f3];
      end
      5'b01101: begin e.kind = K_WB; e.alufn = A_PASS; e.sb = 1'b1; end        // LUI
      5'b00101: begin e.kind = K_WB; e.sa = 1'b1; e.sb = 1'b1; end              // AUIPC
      5'b00000: begin e.kind = K_MEM; e.ld = 1'b1; e.sb = 1'b1; end             // LOAD
      5'b01000: begin e.kind = K_MEM; e.st = 1'b1; e.sb = 1'b1; end             // STORE
      5'b11000: begin  // BRANCH
        if (f3 == 3'd2 || f3 == 3'd3) return e;
        case (f3)
          3'd0:    tk = z;
          3'd1:    tk = !z;
          3'd4:    tk = (s != v);
          3'd5:    tk = (s == v);
          3'd6:    tk = !cy;
          default: tk = cy;
        endcase
        e.kind = K_CTRL; e.alufn = A_SUB; e.sel = tk ? 2'b11 : e.ft;
      end
      5'b11011: begin e.kind = K_CTRL; e.chk_alu = 1'b0; e.sel = 2'b11; e.rfwe = 1'b1; end  // JAL
      5'b11001: begin e.kind = K_CTRL; e.sb = 1'b1; e.sel = 2'b01; e.rfwe = 1'b1; end       // JALR
      5'b11100: e.cause = (f3 == 3'd0) ? 2'b11 : 2'b01;                                      // SYSTEM
      default: ;
    endcase
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.i_ack = 1'b0;
    bus.d_ack = 1'b0;
    @(negedge clk);
    check("rst_strobes", 32'({bus.i_req, bus.d_req, pc_load, rf_we}), 0);
    next_cycle();
    @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_ir", ir, 32'h0000_0013);
    check("rst_trap", 32'({trap, trap_cause}), 0);
    check("rst_ireq", 32'(bus.i_req), 0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic trap_hold(input logic [1:0] cause);
    for (int k = 0; k < 3; k++) begin
      bus.i_ack = 1'($urandom);
      bus.d_ack = 1'($urandom);
      @(negedge clk);
      check("trap_state", 32'(state), 5);
      check("trap_flag", 32'(trap), 1);
      check("trap_cause", 32'(trap_cause), 32'(cause));
      check("trap_strobes", 32'({bus.i_req, bus.d_req, pc_load, rf_we}), 0);
      next_cycle();
    end
    do_reset();
  endtask

  // Runs one instruction; starts and ends one tick after a rising edge
  task automatic run_instr(input logic [31:0] x, input logic c, input int fw,
                           input int mw, input logic [3:0] fl);
    exp_t e;
    bit   acked;
    e = model(x, c, fl);
    {zf, cf, vf, sf} = fl;
    acked = 1'b0;
    for (int k = 0; k < TO && !acked; k++) begin
      bus.i_ack   = (k == fw);
      bus.i_rdata = (k == fw) ? x : $urandom;
      bus.i_c     = c;
      @(negedge clk);
      check("fetch_state", 32'(state), 0);
      check("fetch_ireq", 32'(bus.i_req), 1);
      check("fetch_quiet", 32'({bus.d_req, pc_load, rf_we}), 0);
      acked = (k == fw);
      next_cycle();
      bus.i_ack = 1'b0;
    end
    if (!acked) begin
      trap_hold(2'b10);
      return;
    end
    @(negedge clk);
    check("dec_state", 32'(state), 1);
    check("dec_ir", ir, x);
    check("dec_quiet", 32'({bus.i_req, bus.d_req, pc_load, rf_we}), 0);
    next_cycle();
    if (e.kind == K_TRAP) begin
      trap_hold(e.cause);
      return;
    end
    @(negedge clk);
    check("exec_state", 32'(state), 2);
    if (e.chk_alu) begin
      check("exec_alufn", 32'(alufn), 32'(e.alufn));
      check("exec_src", 32'({alu_src_a, alu_src_b}), 32'({e.sa, e.sb}));
    end
    if (e.kind == K_CTRL) begin
      check("ctrl_pcld", 32'(pc_load), 1);
      check("ctrl_sel", 32'(pc_sel), 32'(e.sel));
      check("ctrl_rfwe", 32'(rf_we), 32'(e.rfwe));
      if (e.rfwe) check("ctrl_wbsel", 32'(wb_sel), 2);
      next_cycle();
      return;
    end
    check("exec_quiet", 32'({bus.i_req, pc_load, rf_we}), 0);
    next_cycle();
    if (e.kind == K_MEM) begin
      acked = 1'b0;
      for (int k = 0; k < TO && !acked; k++) begin
        bus.d_ack = (k == mw);
        @(negedge clk);
        check("mem_state", 32'(state), 3);
        check("mem_dreq", 32'(bus.d_req), 1);
        check("mem_dwe", 32'(bus.d_we), 32'(e.st));
        if (k == mw) begin
          check("mem_pcld", 32'(pc_load), 1);
          check("mem_sel", 32'(pc_sel), 32'(e.ft));
          check("mem_rfwe", 32'(rf_we), 32'(e.ld));
          if (e.ld) check("mem_wbsel", 32'(wb_sel), 1);
        end else begin
          check("mem_wait", 32'({pc_load, rf_we}), 0);
        end
        acked = (k == mw);
        next_cycle();
        bus.d_ack = 1'b0;
      end
      if (!acked) trap_hold(2'b10);
      return;
    end
    @(negedge clk);
    check("wb_state", 32'(state), 4);
    check("wb_rfwe", 32'(rf_we), 1);
    check("wb_wbsel", 32'(wb_sel), 0);
    check("wb_pcld", 32'(pc_load), 1);
    check("wb_sel", 32'(pc_sel), 32'(e.ft));
    check("wb_alufn", 32'(alufn), 32'(e.alufn));
    next_cycle();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [4:0]  op;
    logic [1:0]  lo;
    int          k;
    r  = $urandom;
    k  = $urandom_range(0, 15);
    lo = 2'b11;
    case (k)
      0, 1:    op = 5'b01100;
      2, 3:    op = 5'b00100;
      4:       op = 5'b01101;
      5:       op = 5'b00101;
      6, 7:    op = 5'b00000;
      8:       op = 5'b01000;
      9, 10:   op = 5'b11000;
      11:      op = 5'b11011;
      12:      op = 5'b11001;
      13:      op = 5'b11100;
      14:      op = r[6:2];
      default: begin op = 5'b00100; lo = r[1:0]; end
    endcase
    return {r[31:7], op, lo};
  endfunction

  initial begin
    logic [31:0] x;
    int          fw, mw;

    rst = 1'b1;
    bus.i_ack = 1'b0; bus.i_rdata = '0; bus.i_c = 1'b0; bus.d_ack = 1'b0;
    {zf, cf, vf, sf} = 4'b0000;
    do_reset();

    // Directed cases
    run_instr(32'h002081B3, 1'b0, 0, 0, 4'b0000);      // ADD x3,x1,x2
    run_instr(32'h402081B3, 1'b0, 1, 0, 4'b0000);      // SUB
    run_instr(32'h4020D1B3, 1'b0, 0, 0, 4'b0000);      // SRA
    run_instr(32'h40108093, 1'b0, 0, 0, 4'b0000);      // ADDI with ir[30] set stays ADD
    run_instr(32'h00208063, 1'b0, 0, 0, 4'b1000);      // BEQ taken
    run_instr(32'h00208063, 1'b0, 0, 0, 4'b0000);      // BEQ not taken
    run_instr(32'h0000A183, 1'b0, 0, 3, 4'b0000);      // LW, d_ack after 3 waits
    run_instr(32'h0020A023, 1'b0, 2, 0, 4'b0000);      // SW
    run_instr(32'h002081B3, 1'b0, TO - 1, 0, 4'b0000); // fetch ack in the timeout cycle
    run_instr(32'h002081B3, 1'b0, TO, 0, 4'b0000);     // fetch timeout
    run_instr(32'h0000A183, 1'b0, 0, TO, 4'b0000);     // data timeout
    run_instr(32'h00000073, 1'b0, 0, 0, 4'b0000);      // ECALL
    run_instr(32'h0000007F, 1'b0, 0, 0, 4'b0000);      // unknown opcode
    run_instr(32'h00000001, 1'b0, 0, 0, 4'b0000);      // ir[1:0] = 01, not compressed
    run_instr(32'h0000A0E3, 1'b0, 0, 0, 4'b0000);      // branch funct3 010
    run_instr(32'h00100093, 1'b1, 0, 0, 4'b0000);      // ADDI flagged compressed
    run_instr(32'h008000EF, 1'b0, 0, 0, 4'b0000);      // JAL
    run_instr(32'h00008067, 1'b0, 0, 0, 4'b0000);      // JALR

    // Reset in the EXEC cycle of a JAL suppresses its strobes
    bus.i_ack = 1'b1; bus.i_rdata = 32'h008000EF; bus.i_c = 1'b0;
    @(negedge clk);
    check("abort_fetch", 32'(bus.i_req), 1);
    next_cycle();
    bus.i_ack = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(state), 2);
    check("abort_strobes", 32'({pc_load, rf_we}), 0);
    next_cycle();
    @(negedge clk);
    check("abort_reset", 32'(state), 0);
    check("abort_ir", ir, 32'h0000_0013);
    next_cycle();
    rst = 1'b0;

    // Randomized instructions, wait states and flags
    for (int n = 0; n < 300; n++) begin
      x  = gen_instr();
      fw = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1));
      mw = ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1));
      run_instr(x, 1'($urandom), fw, mw, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
